// File: rtl/fft_frame_streamer.sv
// rtl/fft_frame_streamer.sv - captures one flattened complex frame per load and streams it out sample by sample.
// Optional pending-frame buffer enabled by defining FFT_STREAM_PINGPONG_EN.
module fft_frame_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16,
  localparam int IDX_W     = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_load,
  input  logic [N*DATA_WIDTH-1:0] frame_real,
  input  logic [N*DATA_WIDTH-1:0] frame_imag,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_real,
  output logic [DATA_WIDTH-1:0]   m_imag,
  output logic [IDX_W-1:0]        m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int FW = N * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [FW-1:0]     act_real, act_imag;
  logic              stream_st, handshake, final_hs;
  logic              load_active, promote, drop;

  assign stream_st = (state == STREAM);
  assign handshake = stream_st & m_ready;
  assign final_hs  = handshake & (idx == LAST_IDX);

`ifdef FFT_STREAM_PINGPONG_EN
  logic [FW-1:0] pend_real, pend_imag;
  logic          pend_full, load_pend;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (frame_load) state_nxt = STREAM;
      STREAM: if (final_hs && !load_active && !promote) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid = stream_st;
    busy    = stream_st;
    m_last  = stream_st & (idx == LAST_IDX);
    m_real  = stream_st ? act_real[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    m_imag  = stream_st ? act_imag[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    m_index = stream_st ? idx : '0;
`ifdef FFT_STREAM_PINGPONG_EN
    // A load on the final handshake goes to pending only if pending is about to be promoted.
    load_active = frame_load & (!stream_st | (final_hs & !pend_full));
    promote     = final_hs & pend_full;
    load_pend   = frame_load & stream_st & (final_hs ? pend_full : !pend_full);
    drop        = frame_load & stream_st & !final_hs & pend_full;
`else
    load_active = frame_load & (!stream_st | final_hs);
    promote     = 1'b0;
    drop        = frame_load & stream_st & !final_hs;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      act_real   <= '0;
      act_imag   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_active) begin
        act_real <= frame_real;
        act_imag <= frame_imag;
        idx      <= '0;
`ifdef FFT_STREAM_PINGPONG_EN
      end else if (promote) begin
        act_real <= pend_real;
        act_imag <= pend_imag;
        idx      <= '0;
`endif
      end else if (handshake) begin
        idx <= idx + 1'b1;
      end
      frame_done <= final_hs;
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

`ifdef FFT_STREAM_PINGPONG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_real <= '0;
      pend_imag <= '0;
      pend_full <= 1'b0;
    end else begin
      if (load_pend) begin
        pend_real <= frame_real;
        pend_imag <= frame_imag;
      end
      if (load_pend)    pend_full <= 1'b1;
      else if (promote) pend_full <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb/tb_fft_frame_streamer.sv - randomized and directed checks of fft_frame_streamer against a frame-queue model.
module tb_fft_frame_streamer;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int IW = $clog2(N);
  localparam int FW = N * DW;
`ifdef FFT_STREAM_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_load = 1'b0;
  logic [FW-1:0] nxt_re = '0, nxt_im = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_real, m_imag;
  logic [IW-1:0] m_index;
  logic          m_last, busy, frame_done, overrun;
  logic          clr_overrun = 1'b0;

  fft_frame_streamer #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .frame_load(frame_load),
    .frame_real(nxt_re), .frame_imag(nxt_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the frame being played, its read position, and a queue of frames waiting behind it.
  bit            md_streaming = 0;
  int            md_pos = 0;
  logic [FW-1:0] cur_re = '0, cur_im = '0;
  logic [FW-1:0] pq_re[$], pq_im[$];
  bit            md_done = 0, md_ovr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    md_streaming = 0; md_pos = 0; md_done = 0; md_ovr = 0;
    pq_re.delete(); pq_im.delete();
  endtask

  task automatic model_update(input bit ld, input bit rdy, input bit clr);
    bit hs, fin, drop;
    hs = md_streaming && rdy;
    fin = hs && (md_pos == N - 1);
    drop = 0;
    if (!md_streaming) begin
      if (ld) begin cur_re = nxt_re; cur_im = nxt_im; md_pos = 0; md_streaming = 1; end
    end else if (fin) begin
      if (pq_re.size() > 0) begin
        cur_re = pq_re.pop_front(); cur_im = pq_im.pop_front(); md_pos = 0;
        if (ld) begin pq_re.push_back(nxt_re); pq_im.push_back(nxt_im); end
      end else if (ld) begin
        cur_re = nxt_re; cur_im = nxt_im; md_pos = 0;
      end else begin
        md_streaming = 0; md_pos = 0;
      end
    end else begin
      if (hs) md_pos++;
      if (ld) begin
        if (PP && pq_re.size() == 0) begin pq_re.push_back(nxt_re); pq_im.push_back(nxt_im); end
        else drop = 1;
      end
    end
    md_done = fin;
    md_ovr = drop ? 1'b1 : (clr ? 1'b0 : md_ovr);
  endtask

  task automatic step(input bit ld, input bit rdy, input bit clr);
    @(negedge clk);
    check("m_valid", 32'(m_valid), 32'(md_streaming));
    check("busy", 32'(busy), 32'(md_streaming));
    check("frame_done", 32'(frame_done), 32'(md_done));
    check("overrun", 32'(overrun), 32'(md_ovr));
    if (md_streaming) begin
      check("m_real", 32'(m_real), 32'(cur_re[md_pos*DW +: DW]));
      check("m_imag", 32'(m_imag), 32'(cur_im[md_pos*DW +: DW]));
      check("m_index", 32'(m_index), 32'(md_pos));
      check("m_last", 32'(m_last), 32'(md_pos == N - 1));
    end
    frame_load = ld; m_ready = rdy; clr_overrun = clr;
    model_update(ld, rdy, clr);
    @(posedge clk);
    #1;
    frame_load = 0; clr_overrun = 0;
  endtask

  task automatic set_frame(input int mul, input int imul);
    for (int k = 0; k < N; k++) begin
      nxt_re[k*DW +: DW] = DW'(mul * k);
      nxt_im[k*DW +: DW] = DW'(imul * k);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) begin
      nxt_re[k*DW +: DW] = DW'($urandom);
      nxt_im[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic run_to(input int p);
    for (int b = 0; b < 4 * N && md_streaming && md_pos != p; b++) step(0, 1, 0);
  endtask

  task automatic drain();
    for (int b = 0; b < 6 * N && md_streaming; b++) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
  endtask

  initial begin
    #12;
    check("reset m_valid", 32'(m_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset m_real", 32'(m_real), 0);
    check("reset m_index", 32'(m_index), 0);
    check("reset m_last", 32'(m_last), 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    step(0, 1, 0);

    // basic stream
    set_frame(100, -1);
    step(1, 1, 0);
    drain();

    // backpressure at index 5
    step(1, 1, 0);
    run_to(5);
    repeat (3) step(0, 0, 0);
    check("stall m_real", 32'(m_real), 32'(500));
    check("stall m_imag", 32'(m_imag), 32'(16'hFFFB));
    drain();

    // back-to-back on the final handshake
    step(1, 1, 0);
    run_to(N - 1);
    set_frame(7, 0);
    step(1, 1, 0);
    drain();

    // extra loads during a frame, then clear, then drop coinciding with clear
    set_frame(100, -1);
    step(1, 1, 0);
    run_to(3);
    set_frame(3, 5);
    step(1, 1, 0);
    run_to(5);
    set_frame(-9, 2);
    step(1, 1, 0);
    drain();
    step(0, 1, 1);
    step(0, 1, 0);
    set_frame(100, -1);
    step(1, 1, 0);
    run_to(2);
    step(1, 1, 1);
    step(1, 1, 1);
    drain();
    step(0, 1, 1);

    // reset mid-frame
    step(1, 1, 0);
    run_to(8);
    @(negedge clk);
    #2 reset = 1;
    #1;
    check("rst m_valid", 32'(m_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst overrun", 32'(overrun), 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (4) step(0, 1, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit ld, rdy, clr;
      rdy = ($urandom_range(0, 3) != 0);
      ld = (md_streaming && md_pos == N - 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 30) == 0);
      if (ld) rand_frame();
      step(ld, rdy, clr);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Sits downstream of the FFT bit-reversal reorder stage and consumes one flattened N-sample complex frame per load strobe.
- Captures the frame into an internal buffer and streams it out one complex sample per cycle, in index order, over a valid/ready interface toward the chiplet output path.
- Reports frame completion, busy status and dropped-frame overruns to the controller.

Parameters:
- DATA_WIDTH, 16, bits per real or imaginary sample (signed, two's complement).
- N, 16, samples per frame; power of two, N >= 2.
- IDX_W, $clog2(N), width of the sample index (derived localparam, not overridable).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- frame_load  in  1  single-cycle strobe: capture frame_real/frame_imag this cycle (driven by the reorder done pulse).
- frame_real  in  N*DATA_WIDTH  flattened real parts; sample k at [k*DATA_WIDTH +: DATA_WIDTH].
- frame_imag  in  N*DATA_WIDTH  flattened imaginary parts, same packing.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts the sample when m_valid and m_ready are both high.
- m_real  out  DATA_WIDTH  real part of the current sample.
- m_imag  out  DATA_WIDTH  imaginary part of the current sample.
- m_index  out  IDX_W  index of the current sample within its frame.
- m_last  out  1  high with m_valid when m_index == N-1.
- busy  out  1  a frame is being streamed (state STREAM).
- frame_done  out  1  one-cycle pulse after the final handshake of a frame.
- overrun  out  1  sticky: a frame_load was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async): state IDLE, idx=0, m_valid=0, busy=0, frame_done=0, overrun=0, buffers cleared to 0. m_real/m_imag/m_index read as 0 and m_last as 0.
- States:
  - IDLE: frame_load -> capture into the active buffer, idx=0, go to STREAM. m_valid=1 from the next cycle (latency 1).
  - STREAM: m_valid=1, m_real/m_imag = active_buf[idx], m_index = idx.
    - On handshake with idx<N-1: idx+1.
    - On handshake with idx==N-1: frame complete, frame_done=1 next cycle. Go to IDLE with m_valid=0, unless a new frame is taken (see below).
- Stall: while m_valid && !m_ready, m_real/m_imag/m_index/m_last are held stable. m_valid never drops without a handshake.
- Load acceptance (no ping-pong build): frame_load is accepted in IDLE, or in the same cycle as the final handshake. In the final-handshake case the new frame is captured, idx=0, and the state stays STREAM with no bubble; frame_done still pulses.
  - Any other frame_load during STREAM is dropped: overrun=1 next cycle, and the current frame is unaffected.
- Overrun: clr_overrun clears it. If a drop and clr_overrun occur in the same cycle, overrun ends up set (the set wins).
- Datapath is a pure move: no arithmetic, sign preserved bit-exact.
- frame_load held high for multiple cycles counts as one load per cycle; each extra cycle is handled by the rules above.
- Reset mid-frame discards all buffered data; no frame_done is generated.

Optional Feature:
- Macro FFT_STREAM_PINGPONG_EN.
- Defined: adds a second (pending) frame buffer.
  - frame_load during STREAM with pending empty -> capture to pending, no overrun.
  - On final handshake with pending full -> pending becomes active, idx=0, no bubble. A frame_load in that same cycle is captured into pending (accepted).
  - frame_load with pending full and no final handshake -> dropped, overrun=1.
- Not defined: single buffer only, acceptance and overrun rules as above.

Test Plan:
- Basic stream: N=16, DATA_WIDTH=16, sample k real=100*k, imag=-k; pulse frame_load, m_ready=1 -> m_valid rises 1 cycle later; 16 consecutive handshakes with m_index 0..15, m_real 0,100..1500, m_imag 0,-1..-15; m_last only at index 15; frame_done pulses 1 cycle after; busy then 0.
- Backpressure: same frame, m_ready low for 3 cycles at index 5 -> m_real=500, m_imag=-5, m_index=5 held stable; stream resumes at 6; total 16 handshakes, no duplicates or skips.
- Back-to-back: second frame (real=7*k) loaded in the final-handshake cycle of the first -> next cycle m_valid=1, m_index=0, m_real=0, then 7, 14...; no bubble; frame_done pulses once per frame.
- Overrun (no macro): frame_load at index 3 of a frame -> overrun=1, streaming continues with the original data through index 15; clr_overrun -> overrun=0 next cycle. Drop and clear in the same cycle -> overrun=1.
- Ping-pong (macro defined): load at index 3 -> no overrun, second frame follows immediately after index 15; a third load before the handoff -> overrun=1.
- Reset mid-frame: assert reset at index 8 -> m_valid, busy, frame_done, overrun all 0 immediately; after release, no output until the next frame_load.
